inst_cache_assoc: RTL and testbench
===================================

Name: inst_cache_assoc

Overview:
Parametrised, set-associative successor to the direct-mapped instruction cache. It sits between the core fetch port (inst_addr/inst_data/inst_valid) and the line-fill memory port (addr/data/rd/ack). It adds configurable way count, set count and line width, plus per-set round-robin replacement. It also supports a fence flush (mem_fc) that stays correct when it arrives during an outstanding fill.

Parameters:
WAYS, 2, associativity; legal values 1, 2, 4.
SETS, 8, number of sets; power of two, at least 2.
LINE_WORDS, 8, 32-bit words per line; power of two, at least 2; the fill bus is 32*LINE_WORDS bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
inst_addr_i  input  32  fetch byte address; bits [1:0] ignored.
inst_data_o  output  32  fetched instruction word.
inst_valid_o  output  1  inst_data_o valid for inst_addr_i this cycle.
mem_fc  input  1  fence/flush request; single-cycle pulse, invalidates the whole cache.
addr_o  output  32  line-aligned fill address.
data_i  input  32*LINE_WORDS  fill line; word 0 in bits [31:0].
rd_o  output  1  fill request.
ack_i  input  1  fill complete; data_i valid in the same cycle.

Behaviour:
- Address split:
  - offset = addr[$clog2(LINE_WORDS)+1:2]
  - index = next $clog2(SETS) bits
  - tag = remaining upper bits
- Storage: data, tag and valid arrays are flop-based; reads are asynchronous.
- Hit path:
  - In IDLE, a hit is any way with valid && tag match.
  - On a hit, inst_valid_o=1 and inst_data_o = the selected word, combinationally in the same cycle (zero latency).
  - Tags in a set are never duplicated, so at most one way can match.
- FSM states: IDLE, FILL.
  - IDLE, miss: latch the line-aligned inst_addr_i into addr_o. Go to FILL. rd_o=1 from the next cycle.
  - FILL: hold rd_o=1 and addr_o stable until ack_i=1. Ignore changes on inst_addr_i. inst_valid_o=0.
  - FILL, ack_i=1: write data_i and the tag into the victim way on that edge. Set its valid bit unless the fill is poisoned. Drop rd_o. Return to IDLE.
  - The refetch then hits on the following cycle, so miss-to-valid latency is 1 + memory latency + 1 cycles.
- ack_i outside FILL is ignored.
- Victim selection:
  - Pick the lowest-index invalid way in the set.
  - If every way is valid, pick the per-set round-robin pointer (log2(WAYS) bits).
  - The pointer increments, modulo WAYS, on every fill into that set.
  - With WAYS=1, there is no pointer and the victim is always way 0.
- mem_fc:
  - In IDLE: clear all valid bits on that edge. inst_valid_o=0 in the same cycle as the pulse. Replacement pointers are unchanged.
  - In FILL: clear all valid bits and set poison. The fill still completes its handshake, but its valid bit stays 0. The next lookup misses and starts a new fill.
  - mem_fc coinciding with ack_i: treat as poisoned; the line is not valid afterwards.
- Reset (rst=1 at an edge):
  - Clears all valid bits, replacement pointers and poison.
  - FSM goes to IDLE; rd_o=0 and addr_o=0 from the next cycle.
  - This applies even mid-fill: the outstanding fill is abandoned and a late ack_i is ignored.
  - inst_valid_o=0 while the cache is empty. Data and tag arrays are not reset.

Optional Feature:
INST_CACHE_STATS_EN
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - hit_count_o increments each IDLE cycle with a hit.
  - miss_count_o increments on each IDLE-to-FILL transition.
  - Both are cleared by rst and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
Configuration WAYS=2, SETS=8, LINE_WORDS=8: offset = addr[4:2], index = addr[7:5], tag = addr[31:8]. Memory acks 7 cycles after rd_o rises.
1. Cold miss: after rst, fetch 0x00000000 -> rd_o=1 with addr_o=0x00000000 one cycle later, held until ack. Following cycle inst_valid_o=1 and inst_data_o = word 0 of the line. miss_count_o=1.
2. Hit: then fetch 0x00000014 -> inst_valid_o=1 in the same cycle, data = word 5, rd_o stays 0, hit_count_o increments.
3. Conflict: fill 0x000, then 0x100 (both set 0, ways 0/1) -> both hit. Fetch 0x200 -> evicts way 0 (pointer=0 after two fills). Then 0x100 hits and 0x000 misses.
4. Flush in IDLE: with 0x000 cached, pulse mem_fc -> inst_valid_o=0 that cycle. Refetch 0x000 issues rd_o.
5. Flush during FILL: pulse mem_fc 3 cycles after rd_o rises -> handshake completes. The cycle after ack, inst_valid_o=0 and a new rd_o for the same address follows.
6. Reset mid-fill: assert rst while rd_o=1 -> rd_o=0 next cycle. A late ack_i has no effect. The next fetch misses.

Source files
------------

// File: rtl/inst_cache_assoc_if.sv
// inst_cache_assoc_if: fetch port and line-fill memory port of the set-associative instruction cache
interface inst_cache_assoc_if #(parameter int LINE_WORDS = 8);
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic inst_valid_o;
  logic mem_fc;
  logic [31:0] addr_o;
  logic [32*LINE_WORDS-1:0] data_i;
  logic rd_o;
  logic ack_i;
  modport slave (input inst_addr_i, mem_fc, data_i, ack_i, output inst_data_o, inst_valid_o, addr_o, rd_o);
  modport master (output inst_addr_i, mem_fc, data_i, ack_i, input inst_data_o, inst_valid_o, addr_o, rd_o);
endinterface

// File: rtl/inst_cache_assoc.sv
// inst_cache_assoc: set-associative instruction cache with round-robin replacement and fence flush
// INST_CACHE_STATS_EN adds hit_count_o/miss_count_o counters.
module inst_cache_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  parameter int LINE_WORDS = 8
) (
  input logic clk,
  input logic rst,
  inst_cache_assoc_if.slave bus
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;
  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic poison;
  logic [32*LINE_WORDS-1:0] data_q [SETS][WAYS];
  logic [TW-1:0] tag_q [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [PW-1:0] ptr_q [SETS];
  logic [OW-1:0] off;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] tag, ftag;
  logic hit;
  logic [PW-1:0] hit_way, victim;
  logic unused;
  assign off = bus.inst_addr_i[OW+1:2];
  assign idx = bus.inst_addr_i[OW+2 +: IW];
  assign tag = bus.inst_addr_i[31 -: TW];
  assign fidx = bus.addr_o[OW+2 +: IW];
  assign ftag = bus.addr_o[31 -: TW];
  assign unused = ^{bus.inst_addr_i[1:0], bus.addr_o[OW+1:0]};
  // Descending scan: the last invalid way seen is the lowest-index one.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = ptr_q[fidx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = PW'(w);
      end
      if (!valid_q[fidx][w]) victim = PW'(w);
    end
  end
  assign bus.inst_valid_o = state == IDLE && hit && !bus.mem_fc;
  assign bus.inst_data_o = data_q[idx][hit_way][32*off +: 32];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      poison <= 1'b0;
      bus.rd_o <= 1'b0;
      bus.addr_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s] <= '0;
      end
    end else if (state == IDLE) begin
      if (bus.mem_fc) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (!hit) begin
        state <= FILL;
        bus.rd_o <= 1'b1;
        bus.addr_o <= {bus.inst_addr_i[31:OW+2], {(OW+2){1'b0}}};
      end
    end else begin
      if (bus.mem_fc) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        poison <= 1'b1;
      end
      if (bus.ack_i) begin
        state <= IDLE;
        bus.rd_o <= 1'b0;
        poison <= 1'b0;
        valid_q[fidx][victim] <= !(poison || bus.mem_fc);
        ptr_q[fidx] <= (WAYS > 1) ? ptr_q[fidx] + 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && bus.ack_i) begin
      data_q[fidx][victim] <= bus.data_i;
      tag_q[fidx][victim] <= ftag;
    end
  end
`ifdef INST_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_o <= '0;
      miss_count_o <= '0;
    end else begin
      if (bus.inst_valid_o) hit_count_o <= hit_count_o + 1'b1;
      if (state == IDLE && !bus.mem_fc && !hit) miss_count_o <= miss_count_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_cache_assoc.sv
// tb_inst_cache_assoc: randomized fetch stream against a transaction-level cache model
module tb_inst_cache_assoc;
  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int LW = 8;
  localparam int LAT = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_ack = 1'b0;
  logic f_ack = 1'b0;
  logic mute = 1'b0;
  int rcnt = 0;
  int checks = 0;
  int errors = 0;
  logic [23:0] mtag [SETS][WAYS];
  bit mval [SETS][WAYS];
  int mptr [SETS];
  int mhit = 0;
  int mmiss = 0;
  always #5 clk = ~clk;
  inst_cache_assoc_if #(.LINE_WORDS(LW)) bus ();
  assign bus.ack_i = r_ack | f_ack;
`ifdef INST_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  inst_cache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef INST_CACHE_STATS_EN
    ,
    .hit_count_o(hit_count),
    .miss_count_o(miss_count)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++) if (mval[a[7:5]][w] && mtag[a[7:5]][w] == a[31:8]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_clear();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
  endtask
  task automatic model_fill(input logic [31:0] a, input bit poisoned);
    int s = int'(a[7:5]);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!mval[s][w] && v < 0) v = w;
    if (v < 0) v = mptr[s];
    mptr[s] = (mptr[s] + 1) % WAYS;
    mtag[s][v] = a[31:8];
    if (poisoned) model_clear();
    else mval[s][v] = 1'b1;
  endtask
  task automatic stats_check();
`ifdef INST_CACHE_STATS_EN
    check("hit_count", hit_count, mhit);
    check("miss_count", miss_count, mmiss);
`endif
  endtask
  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask
  // Called at the negedge of the IDLE miss cycle; follows the fill (and any refill after a poisoned one).
  task automatic do_fill(input logic [31:0] a, input int fc_at);
    bit poisoned;
    bit got;
    int n;
    int fc = fc_at;
    do begin
      mmiss++;
      poisoned = 1'b0;
      got = 1'b0;
      for (n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        f_ack = 1'b0;
        bus.mem_fc = (n == fc);
        if (n == fc) poisoned = 1'b1;
        @(negedge clk);
        check("fill_rd", bus.rd_o, 1);
        check("fill_addr", bus.addr_o, a & ~32'h1F);
        check("fill_valid", bus.inst_valid_o, 0);
        if (bus.ack_i) begin
          got = 1'b1;
          break;
        end
        bus.inst_addr_i = $urandom;
      end
      if (!got) begin
        check("ack_timeout", 0, 1);
        finish_run();
      end
      check("fill_latency", n, LAT - 1);
      bus.inst_addr_i = a;
      @(posedge clk);
      #1;
      bus.mem_fc = 1'b0;
      @(negedge clk);
      model_fill(a, poisoned);
      check("post_rd", bus.rd_o, 0);
      if (poisoned) check("poison_valid", bus.inst_valid_o, 0);
      else begin
        check("refetch_valid", bus.inst_valid_o, 1);
        check("refetch_data", bus.inst_data_o, mem_word(a));
        mhit++;
      end
      fc = -1;
    end while (poisoned);
  endtask
  task automatic fetch(input logic [31:0] a, input int fc_at);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_fc = 1'b0;
    bus.inst_addr_i = a;
    stats_check();
    @(negedge clk);
    if (model_hit(a)) begin
      check("hit_valid", bus.inst_valid_o, 1);
      check("hit_data", bus.inst_data_o, mem_word(a));
      check("hit_rd", bus.rd_o, 0);
      mhit++;
    end else begin
      check("miss_valid", bus.inst_valid_o, 0);
      do_fill(a, fc_at);
    end
  endtask
  task automatic flush_idle(input logic [31:0] a);
    @(posedge clk);
    #1;
    bus.inst_addr_i = a;
    bus.mem_fc = 1'b1;
    @(negedge clk);
    check("flush_valid", bus.inst_valid_o, 0);
    model_clear();
  endtask
  initial begin
    bus.data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (r_ack) r_ack = 1'b0;
      else if (bus.rd_o && !mute) begin
        rcnt++;
        if (rcnt == LAT) begin
          for (int i = 0; i < LW; i++) bus.data_i[32*i +: 32] = mem_word(bus.addr_o + 32'(4 * i));
          r_ack = 1'b1;
          rcnt = 0;
        end
      end else rcnt = 0;
    end
  end
  initial begin
    logic [31:0] a;
    int r;
    bus.inst_addr_i = '0;
    bus.mem_fc = 1'b0;
    model_clear();
    for (int s = 0; s < SETS; s++) mptr[s] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", bus.rd_o, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_valid", bus.inst_valid_o, 0);
    fetch(32'h0000_0000, -1);
    fetch(32'h0000_0014, -1);
    fetch(32'h0000_0100, -1);
    fetch(32'h0000_0000, -1);
    fetch(32'h0000_0104, -1);
    fetch(32'h0000_0200, -1);
    fetch(32'h0000_0108, -1);
    fetch(32'h0000_0000, -1);
    flush_idle(32'h0000_0000);
    fetch(32'h0000_0000, -1);
    fetch(32'h0000_0520, 3);
    fetch(32'h0000_0640, 6);
    fetch(32'h0000_0520, -1);
    a = 32'h0000_3C40;
    mute = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_addr_i = a;
    @(negedge clk);
    check("rm_miss", bus.inst_valid_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rm_rd_pre", bus.rd_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rm_rd", bus.rd_o, 0);
    check("rm_addr", bus.addr_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    f_ack = 1'b1;
    mute = 1'b0;
    model_clear();
    for (int s = 0; s < SETS; s++) mptr[s] = 0;
    mhit = 0;
    mmiss = 0;
    @(negedge clk);
    check("late_ack_valid", bus.inst_valid_o, 0);
    check("late_ack_rd", bus.rd_o, 0);
    do_fill(a, -1);
    fetch(32'h0000_0000, -1);
    for (int i = 0; i < 300; i++) begin
      a = 32'(($urandom_range(0, 4) << 8) | ($urandom_range(0, 1) << 5) | ($urandom_range(0, 7) << 2));
      r = int'($urandom_range(0, 19));
      if (r == 0) flush_idle(a);
      fetch(a, (r == 1) ? int'($urandom_range(0, 6)) : -1);
    end
    @(posedge clk);
    #1;
    stats_check();
    finish_run();
  end
endmodule
